// File: rtl/alu_result_if.sv
// Result bus between the ALU bitslice chain and the result stage, and from the stage downstream.
// Ports: in_valid/in_ready handshake with in_f, in_cout, in_ctrl, in_cin, in_a_msb, in_b_msb;
//        out_valid/out_ready handshake with out_f, out_z/n/c/v; last_flags status.
// Modport slave is the stage side, master is the driver/consumer side.
interface alu_result_if #(
  parameter int unsigned WIDTH = 8
) ();
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_f;
  logic             in_cout;
  logic [1:0]       in_ctrl;
  logic             in_cin;
  logic             in_a_msb;
  logic             in_b_msb;

  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_f;
  logic             out_z;
  logic             out_n;
  logic             out_c;
  logic             out_v;
  logic [3:0]       last_flags;

  modport slave (
    input  in_valid, in_f, in_cout, in_ctrl, in_cin, in_a_msb, in_b_msb, out_ready,
    output in_ready, out_valid, out_f, out_z, out_n, out_c, out_v, last_flags
  );

  modport master (
    output in_valid, in_f, in_cout, in_ctrl, in_cin, in_a_msb, in_b_msb, out_ready,
    input  in_ready, out_valid, out_f, out_z, out_n, out_c, out_v, last_flags
  );
endinterface

// File: rtl/alu_result_stage.sv
// ALU result stage: 2-entry FIFO that captures the bitslice chain result, computes
// Z/N/C/V at enqueue and presents the head entry with registered outputs.
// Ports: clk, reset (sync, active-high), bus (alu_result_if.slave) carrying the
//        upstream result handshake, the downstream result handshake and last_flags.
module alu_result_stage #(
  parameter int unsigned WIDTH = 8
) (
  input logic         clk,
  input logic         reset,
  alu_result_if.slave bus
);

  localparam int unsigned DEPTH = 2;
  localparam int unsigned CW    = 2;
  localparam int unsigned FLW   = 4;

  logic [WIDTH-1:0] mem_f_q  [DEPTH];
  logic [WIDTH-1:0] mem_f_d  [DEPTH];
  logic [FLW-1:0]   mem_fl_q [DEPTH];
  logic [FLW-1:0]   mem_fl_d [DEPTH];
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             in_ready_q, out_valid_q;
  logic [WIDTH-1:0] out_f_q, out_f_d;
  logic [FLW-1:0]   out_fl_q, out_fl_d;
  logic [FLW-1:0]   last_q, last_d;
  logic             enq, deq;
  logic             flag_z, flag_n, flag_c, flag_v;
  logic [FLW-1:0]   new_flags;

  // Flags of the incoming result; carry/overflow only meaningful for the arithmetic ctrl.
  always_comb begin
    flag_z = (bus.in_f == '0);
    flag_n = bus.in_f[WIDTH-1];
    flag_c = 1'b0;
    flag_v = 1'b0;
    if (bus.in_ctrl == 2'b00) begin
      flag_c = bus.in_cout;
      // cin=1 selects subtract: overflow when operand signs differ instead of match
      flag_v = (bus.in_cin ? (bus.in_a_msb != bus.in_b_msb) : (bus.in_a_msb == bus.in_b_msb))
               && (bus.in_f[WIDTH-1] != bus.in_a_msb);
    end
    new_flags = {flag_z, flag_n, flag_c, flag_v};
  end

  // FIFO next state; the head of the next state is precomputed so outputs stay registered.
  always_comb begin
    mem_f_d  = mem_f_q;
    mem_fl_d = mem_fl_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    out_f_d  = '0;
    out_fl_d = '0;
    last_d   = last_q;

    // in_ready_q always mirrors count<2, so no combinational path from out_ready
    enq = bus.in_valid && in_ready_q;
    deq = out_valid_q && bus.out_ready;

    if (enq) begin
      mem_f_d[wr_ptr_q]  = bus.in_f;
      mem_fl_d[wr_ptr_q] = new_flags;
      wr_ptr_d           = ~wr_ptr_q;
    end
    if (deq) begin
      rd_ptr_d = ~rd_ptr_q;
      last_d   = out_fl_q;
    end

    count_d = count_q + CW'(enq) - CW'(deq);

    if (count_d != '0) begin
      out_f_d  = mem_f_d[rd_ptr_d];
      out_fl_d = mem_fl_d[rd_ptr_d];
    end
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_f_q[i]  <= '0;
        mem_fl_q[i] <= '0;
      end
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      count_q     <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_f_q     <= '0;
      out_fl_q    <= '0;
      last_q      <= '0;
    end else begin
      mem_f_q     <= mem_f_d;
      mem_fl_q    <= mem_fl_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      in_ready_q  <= (count_d != CW'(DEPTH));
      out_valid_q <= (count_d != '0);
      out_f_q     <= out_f_d;
      out_fl_q    <= out_fl_d;
      last_q      <= last_d;
    end
  end

  assign bus.in_ready   = in_ready_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_f      = out_f_q;
  assign bus.out_z      = out_fl_q[3];
  assign bus.out_n      = out_fl_q[2];
  assign bus.out_c      = out_fl_q[1];
  assign bus.out_v      = out_fl_q[0];
  assign bus.last_flags = last_q;

endmodule

// File: doc/alu_result_stage.md
ALU_RESULT_STAGE -- requirements
Module: alu_result_stage

Interface
REQ-001 Parameter: WIDTH, default 8, datapath width in bits; legal range 2..32.
REQ-002 clk  input  1  rising-edge clock; the only clock.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 in_valid  input  1  upstream ALU result is valid this cycle.
REQ-005 in_ready  output  1  stage can accept a result this cycle.
REQ-006 in_f  input  WIDTH  ALU F outputs, concatenated across the bitslice chain.
REQ-007 in_cout  input  1  carry out of the MSB bitslice.
REQ-008 in_ctrl  input  2  ctrl value applied to the slices for this result.
REQ-009 in_cin  input  1  cin value applied to the LSB slice for this result.
REQ-010 in_a_msb, in_b_msb  input  1 each  MSB of the A and B operands.
REQ-011 out_valid  output  1  head entry is presented.
REQ-012 out_ready  input  1  downstream consumes the head entry.
REQ-013 out_f  output  WIDTH  registered result.
REQ-014 out_z, out_n, out_c, out_v  output  1 each  zero, negative, carry and overflow flags.
REQ-015 last_flags  output  4  {Z,N,C,V} of the most recently dequeued entry.

Function
REQ-016 Storage SHALL be a 2-entry FIFO with an occupancy count of 0..2.
REQ-017 in_ready SHALL equal (count < 2), with no combinational dependence on out_ready.
REQ-018 Enqueue SHALL occur on in_valid && in_ready; dequeue SHALL occur on out_valid && out_ready.
REQ-019 Simultaneous enqueue and dequeue with count=1 SHALL leave count=1 and preserve order.
REQ-020 A full FIFO (count=2) SHALL provide no bypass: in_ready=0 even when out_ready=1.
REQ-021 Latency SHALL be one cycle: data accepted in cycle t appears with out_valid=1 in cycle t+1 when the FIFO was empty.
REQ-022 Entries SHALL dequeue in acceptance order.
REQ-023 Flags SHALL be computed at enqueue and stored with the entry.
REQ-024 Z = (in_f == 0), for every ctrl.
REQ-025 N = in_f[WIDTH-1], for every ctrl.
REQ-026 C = in_cout when in_ctrl=00; otherwise C=0.
REQ-027 V SHALL depend on ctrl and cin:
- ctrl=00, cin=0: V = (a_msb==b_msb) && (f_msb!=a_msb).
- ctrl=00, cin=1: V = (a_msb!=b_msb) && (f_msb!=a_msb).
- any other ctrl: V = 0.
REQ-028 With out_valid=0, out_f and out_z/n/c/v SHALL be 0.
REQ-029 last_flags SHALL update in the cycle after a dequeue and SHALL hold otherwise.
REQ-030 Pointers SHALL wrap modulo 2; no overflow or underflow is possible under the REQ-017/018 rules.
REQ-031 out_valid SHALL equal (count != 0).

Reset
REQ-032 While reset=1 at a clock edge, the stage SHALL set:
- count=0 and both pointers=0;
- out_valid=0 and in_ready=1;
- out_f=0, all flags=0, last_flags=0.
REQ-033 Reset SHALL discard buffered entries, including mid-transfer, and SHALL override a concurrent enqueue or dequeue.
REQ-034 In the first cycle after reset deasserts, the stage SHALL accept input.

Verification
REQ-035 Add overflow: f=0x7F+0x01 → push f=0x80, cout=0, ctrl=00, cin=0, a_msb=0, b_msb=0 → next cycle out_f=0x80, Z=0, N=1, C=0, V=1.
REQ-036 Subtract equal: push f=0x00, cout=1, ctrl=00, cin=1, a_msb=0, b_msb=0 → Z=1, N=0, C=1, V=0; after dequeue, last_flags=4'b1010.
REQ-037 Logic op: push f=0x00, cout=1, ctrl=10, cin=0 → Z=1, C=0, V=0.
REQ-038 Backpressure:
- Stimulus: out_ready=0; push 0x11, 0x22, then offer 0x33.
- Required: in_ready=0 after the second push; 0x33 held.
- Stimulus: raise out_ready.
- Required: output order 0x11, 0x22, 0x33, with no loss or duplication.
REQ-039 Streaming: in_valid=1 and out_ready=1 continuously with count=1 → one result per cycle; count stays 1.
REQ-040 Reset mid-operation: count=2; assert reset for one cycle with in_valid=1 → next cycle out_valid=0, in_ready=1, out_f=0, last_flags=0; the pushed data is not stored.
